// File: rtl/pac_game_state.sv
// Per-frame Pac-Man game-state tracker: dots, fruit, ghosts, score, lives and reversal timer.
// Optional macro PAC_EXTRA_LIFE_EN grants one bonus life when the score first reaches 1000.
module pac_game_state #(
  parameter int LIVES_INIT      = 3,
  parameter int REVERSAL_FRAMES = 300,
  parameter int RESPAWN_FRAMES  = 60,
  parameter int DOT_PTS         = 1,
  parameter int FRUIT_PTS       = 10,
  parameter int GHOST_PTS       = 20
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_clk,
  input  logic [9:0]    pacmanX,
  input  logic [9:0]    pacmanY,
  input  logic [9:0]    ghost_redX,
  input  logic [9:0]    ghost_redY,
  input  logic [9:0]    ghost_greenX,
  input  logic [9:0]    ghost_greenY,
  input  logic [9:0]    ghost_aquaX,
  input  logic [9:0]    ghost_aquaY,
  input  logic [59:0]   fruit_location,
  input  logic [1763:0] dots_init,
  input  logic          restart,
  output logic [1763:0] dots,
  output logic [10:0]   score,
  output logic [1:0]    lives,
  output logic          death,
  output logic          victory,
  output logic          reversal,
  output logic          first_on,
  output logic          second_on,
  output logic          third_on,
  output logic          red_enable,
  output logic          green_enable,
  output logic          aqua_enable,
  output logic          respawn
);

  typedef enum logic [1:0] {S_PLAY, S_HIT, S_DEAD, S_WON} state_t;

  localparam logic [10:0] SCORE_MAX = 11'd1999;
  localparam logic [15:0] REV_LOAD  = 16'(REVERSAL_FRAMES);
  localparam logic [15:0] HIT_LOAD  = 16'(RESPAWN_FRAMES - 1);
  localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);

  function automatic logic [10:0] popcount(input logic [1763:0] v);
    logic [10:0] c;
    c = '0;
    for (int i = 0; i < 1764; i++) c = c + 11'(v[i]);
    return c;
  endfunction

  function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay,
                                   input logic [9:0] bx, input logic [9:0] by);
    logic signed [10:0] dx, dy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, by});
    return (dx > -11'sd8) && (dx < 11'sd8) && (dy > -11'sd8) && (dy < 11'sd8);
  endfunction

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_fc_sync;
  logic [1763:0]  r_dots, w_dots_nxt;
  logic [10:0]    r_dot_count, w_dot_count_nxt;
  logic [10:0]    r_score, w_score_nxt;
  logic [1:0]     r_lives, w_lives_nxt;
  logic           r_death, w_death_nxt;
  logic           r_victory, w_victory_nxt;
  logic           r_reversal, w_reversal_nxt;
  logic           r_respawn, w_respawn_nxt;
  logic [2:0]     r_fruit_on, w_fruit_on_nxt;
  logic [2:0]     r_ghost_en, w_ghost_en_nxt;
  logic [15:0]    r_rev_timer, w_rev_timer_nxt;
  logic [15:0]    r_hit_timer, w_hit_timer_nxt;
`ifdef PAC_EXTRA_LIFE_EN
  logic           r_bonus_armed, w_bonus_armed_nxt;
`endif

  logic           w_tick;
  logic [10:0]    w_cx, w_cy, w_tx, w_ty, w_dot_idx;
  logic           w_dot_valid;
  logic [2:0]     w_fruit_hit, w_ghost_hit;
  logic [10:0]    w_init_count;
  logic [11:0]    w_add, w_score_sum;
  logic           w_fruit_eaten, w_rev_active, w_lethal;

  assign w_tick       = r_fc_sync[1] & ~r_fc_sync[2];
  assign w_cx         = {1'b0, pacmanX} + 11'd4;
  assign w_cy         = {1'b0, pacmanY} + 11'd4;
  assign w_dot_valid  = (w_cx >= 11'd56) && (w_cx <= 11'd391) &&
                        (w_cy >= 11'd56) && (w_cy <= 11'd391);
  assign w_tx         = (w_cx - 11'd56) >> 3;
  assign w_ty         = (w_cy - 11'd56) >> 3;
  assign w_dot_idx    = w_tx * 11'd42 + w_ty;
  assign w_init_count = popcount(dots_init);

  assign w_fruit_hit[0] = overlap(pacmanX, pacmanY, fruit_location[59:50], fruit_location[49:40]);
  assign w_fruit_hit[1] = overlap(pacmanX, pacmanY, fruit_location[39:30], fruit_location[29:20]);
  assign w_fruit_hit[2] = overlap(pacmanX, pacmanY, fruit_location[19:10], fruit_location[9:0]);
  assign w_ghost_hit[0] = overlap(pacmanX, pacmanY, ghost_redX, ghost_redY);
  assign w_ghost_hit[1] = overlap(pacmanX, pacmanY, ghost_greenX, ghost_greenY);
  assign w_ghost_hit[2] = overlap(pacmanX, pacmanY, ghost_aquaX, ghost_aquaY);

  // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_dots_nxt      = r_dots;
    w_dot_count_nxt = r_dot_count;
    w_score_nxt     = r_score;
    w_lives_nxt     = r_lives;
    w_death_nxt     = r_death;
    w_victory_nxt   = r_victory;
    w_respawn_nxt   = 1'b0;
    w_fruit_on_nxt  = r_fruit_on;
    w_ghost_en_nxt  = r_ghost_en;
    w_rev_timer_nxt = r_rev_timer;
    w_hit_timer_nxt = r_hit_timer;
    w_add           = '0;
    w_score_sum     = '0;
    w_fruit_eaten   = 1'b0;
    w_rev_active    = 1'b0;
    w_lethal        = 1'b0;
`ifdef PAC_EXTRA_LIFE_EN
    w_bonus_armed_nxt = r_bonus_armed;
`endif
    if (w_tick) begin
      unique case (r_state)
        S_PLAY: begin
          if (w_dot_valid && r_dots[w_dot_idx]) begin
            w_dots_nxt[w_dot_idx] = 1'b0;
            w_add                 = w_add + 12'(DOT_PTS);
            w_dot_count_nxt       = r_dot_count - 11'd1;
          end
          for (int i = 0; i < 3; i++) begin
            if (r_fruit_on[i] && w_fruit_hit[i]) begin
              w_fruit_on_nxt[i] = 1'b0;
              w_add             = w_add + 12'(FRUIT_PTS);
              w_fruit_eaten     = 1'b1;
            end
          end
          // Fruit eaten this frame already protects against ghosts in the same frame.
          w_rev_active = (r_rev_timer != '0) || w_fruit_eaten;
          if (w_fruit_eaten)           w_rev_timer_nxt = REV_LOAD;
          else if (r_rev_timer != '0)  w_rev_timer_nxt = r_rev_timer - 16'd1;
          for (int i = 0; i < 3; i++) begin
            if (r_ghost_en[i] && w_ghost_hit[i]) begin
              if (w_rev_active) begin
                w_ghost_en_nxt[i] = 1'b0;
                w_add             = w_add + 12'(GHOST_PTS);
              end else begin
                w_lethal = 1'b1;
              end
            end
          end
          w_score_sum = {1'b0, r_score} + w_add;
          w_score_nxt = (w_score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_score_sum[10:0];
          if (w_dot_count_nxt == '0) begin
            w_state_nxt   = S_WON;
            w_victory_nxt = 1'b1;
          end else if (w_lethal) begin
            if (r_lives == 2'd1) begin
              w_state_nxt = S_DEAD;
              w_death_nxt = 1'b1;
            end else begin
              w_state_nxt     = S_HIT;
              w_lives_nxt     = r_lives - 2'd1;
              w_hit_timer_nxt = HIT_LOAD;
              w_respawn_nxt   = 1'b1;
            end
          end
`ifdef PAC_EXTRA_LIFE_EN
          if (r_bonus_armed && (r_score < 11'd1000) && (w_score_nxt >= 11'd1000)) begin
            w_bonus_armed_nxt = 1'b0;
            if ((w_state_nxt != S_DEAD) && (w_lives_nxt != 2'd3)) w_lives_nxt = w_lives_nxt + 2'd1;
          end
`endif
        end
        S_HIT: begin
          if (r_rev_timer != '0) w_rev_timer_nxt = r_rev_timer - 16'd1;
          if (r_hit_timer == '0) w_state_nxt     = S_PLAY;
          else                   w_hit_timer_nxt = r_hit_timer - 16'd1;
        end
        S_DEAD, S_WON: begin
          if (restart) begin
            w_state_nxt     = S_PLAY;
            w_dots_nxt      = dots_init;
            w_dot_count_nxt = w_init_count;
            w_score_nxt     = '0;
            w_lives_nxt     = LIVES_RST;
            w_death_nxt     = 1'b0;
            w_victory_nxt   = 1'b0;
            w_fruit_on_nxt  = 3'b111;
            w_ghost_en_nxt  = 3'b111;
            w_rev_timer_nxt = '0;
            w_hit_timer_nxt = '0;
            w_respawn_nxt   = 1'b1;
`ifdef PAC_EXTRA_LIFE_EN
            w_bonus_armed_nxt = 1'b1;
`endif
          end
        end
      endcase
    end
    w_reversal_nxt = (w_rev_timer_nxt != '0);
  end

  // NOTE: the dot map is a register file, not RAM, so it can take its layout directly on reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fc_sync   <= '0;
      r_state     <= S_PLAY;
      r_dots      <= dots_init;
      r_dot_count <= w_init_count;
      r_score     <= '0;
      r_lives     <= LIVES_RST;
      r_death     <= 1'b0;
      r_victory   <= 1'b0;
      r_reversal  <= 1'b0;
      r_respawn   <= 1'b0;
      r_fruit_on  <= 3'b111;
      r_ghost_en  <= 3'b111;
      r_rev_timer <= '0;
      r_hit_timer <= '0;
`ifdef PAC_EXTRA_LIFE_EN
      r_bonus_armed <= 1'b1;
`endif
    end else begin
      r_fc_sync   <= {r_fc_sync[1:0], frame_clk};
      r_state     <= w_state_nxt;
      r_dots      <= w_dots_nxt;
      r_dot_count <= w_dot_count_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_death     <= w_death_nxt;
      r_victory   <= w_victory_nxt;
      r_reversal  <= w_reversal_nxt;
      r_respawn   <= w_respawn_nxt;
      r_fruit_on  <= w_fruit_on_nxt;
      r_ghost_en  <= w_ghost_en_nxt;
      r_rev_timer <= w_rev_timer_nxt;
      r_hit_timer <= w_hit_timer_nxt;
`ifdef PAC_EXTRA_LIFE_EN
      r_bonus_armed <= w_bonus_armed_nxt;
`endif
    end
  end

  assign dots         = r_dots;
  assign score        = r_score;
  assign lives        = r_lives;
  assign death        = r_death;
  assign victory      = r_victory;
  assign reversal     = r_reversal;
  assign respawn      = r_respawn;
  assign first_on     = r_fruit_on[0];
  assign second_on    = r_fruit_on[1];
  assign third_on     = r_fruit_on[2];
  assign red_enable   = r_ghost_en[0];
  assign green_enable = r_ghost_en[1];
  assign aqua_enable  = r_ghost_en[2];

endmodule

// File: tb/tb_pac_game_state.sv
// Directed bench for pac_game_state: instance A uses default scoring, instance B uses large
// point values to reach score saturation and the optional extra-life threshold.
module tb_pac_game_state;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_clk;
  logic [9:0]    pac_x, pac_y, red_x, red_y, green_x, green_y, aqua_x, aqua_y;
  logic [59:0]   fruit_loc;
  logic [1763:0] dots_init;
  logic          restart;
  logic [9:0]    b_pac_x, b_pac_y, far;
  logic [59:0]   b_fruit;
  logic          b_restart;

  logic [1763:0] a_dots, b_dots;
  logic [10:0]   a_score, b_score;
  logic [1:0]    a_lives, b_lives;
  logic          a_death, a_victory, a_reversal, a_f0, a_f1, a_f2, a_red, a_green, a_aqua, a_respawn;
  logic          b_death, b_victory, b_reversal, b_f0, b_f1, b_f2, b_red, b_green, b_aqua, b_respawn;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int respawn_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (a_respawn === 1'b1) respawn_cnt++;

  pac_game_state u_dut_a (
    .Clk(clk), .Reset(rst), .frame_clk(frame_clk),
    .pacmanX(pac_x), .pacmanY(pac_y),
    .ghost_redX(red_x), .ghost_redY(red_y),
    .ghost_greenX(green_x), .ghost_greenY(green_y),
    .ghost_aquaX(aqua_x), .ghost_aquaY(aqua_y),
    .fruit_location(fruit_loc), .dots_init(dots_init), .restart(restart),
    .dots(a_dots), .score(a_score), .lives(a_lives),
    .death(a_death), .victory(a_victory), .reversal(a_reversal),
    .first_on(a_f0), .second_on(a_f1), .third_on(a_f2),
    .red_enable(a_red), .green_enable(a_green), .aqua_enable(a_aqua),
    .respawn(a_respawn)
  );

  pac_game_state #(.LIVES_INIT(2), .DOT_PTS(500), .FRUIT_PTS(600), .GHOST_PTS(1000)) u_dut_b (
    .Clk(clk), .Reset(rst), .frame_clk(frame_clk),
    .pacmanX(b_pac_x), .pacmanY(b_pac_y),
    .ghost_redX(far), .ghost_redY(far),
    .ghost_greenX(far), .ghost_greenY(far),
    .ghost_aquaX(far), .ghost_aquaY(far),
    .fruit_location(b_fruit), .dots_init(dots_init), .restart(b_restart),
    .dots(b_dots), .score(b_score), .lives(b_lives),
    .death(b_death), .victory(b_victory), .reversal(b_reversal),
    .first_on(b_f0), .second_on(b_f1), .third_on(b_f2),
    .red_enable(b_red), .green_enable(b_green), .aqua_enable(b_aqua),
    .respawn(b_respawn)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); frame_clk = 1'b1;
      repeat (2) @(negedge clk); frame_clk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic park_ghosts();
    red_x = 10'd600; red_y = 10'd600;
    green_x = 10'd650; green_y = 10'd600;
    aqua_x = 10'd600; aqua_y = 10'd650;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_clk = 1'b0; restart = 1'b0; b_restart = 1'b0;
    pac_x = '0; pac_y = '0; b_pac_x = '0; b_pac_y = '0;
    far = 10'd1000; b_fruit = {6{10'd1000}};
    park_ghosts();
    fruit_loc = {10'd200, 10'd200, 10'd700, 10'd700, 10'd750, 10'd700};
    dots_init = '0;
    dots_init[0] = 1'b1; dots_init[42] = 1'b1; dots_init[215] = 1'b1; dots_init[1763] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_score", a_score, 0);
    check("rst_lives", a_lives, 3);
    check("rst_fruit", {a_f2, a_f1, a_f0}, 3'b111);
    check("rst_ghosts", {a_aqua, a_green, a_red}, 3'b111);
    check("rst_status", {a_death, a_victory, a_reversal, a_respawn}, 0);
    check("rst_dots", a_dots === dots_init, 1);
    check("rst_b_lives", b_lives, 2);

    // Instance B: large awards, bonus threshold and saturation
    b_pac_x = 10'd56; b_pac_y = 10'd56; frames(1);
    check("b_score_500", b_score, 500);
    b_pac_x = 10'd64; frames(1);
    check("b_score_1000", b_score, 1000);
`ifdef PAC_EXTRA_LIFE_EN
    check("b_bonus_life", b_lives, 3);
`else
    check("b_no_bonus", b_lives, 2);
`endif
    b_pac_x = 10'd96; b_pac_y = 10'd96; frames(1);
    check("b_score_1500", b_score, 1500);
    b_pac_x = 10'd384; b_pac_y = 10'd384; frames(1);
    check("b_score_sat", b_score, 1999);
    check("b_victory", b_victory, 1);
`ifdef PAC_EXTRA_LIFE_EN
    check("b_lives_final", b_lives, 3);
`else
    check("b_lives_final", b_lives, 2);
`endif
    b_pac_x = '0; b_pac_y = '0;
    check("a_idle_score", a_score, 0);

    // Dot at tile (0,0)
    pac_x = 10'd56; pac_y = 10'd56; frames(1);
    check("dot00_cleared", a_dots[0], 0);
    check("dot00_score", a_score, 1);
    frames(1);
    check("dot00_again", a_score, 1);

    // Fruit 0, then red ghost 5 frames later under reversal
    pac_x = 10'd203; pac_y = 10'd205; frames(1);
    check("fruit0_off", a_f0, 0);
    check("fruit_rev", a_reversal, 1);
    check("fruit_score", a_score, 11);
    pac_x = '0; pac_y = '0; frames(4);
    red_x = 10'd300; red_y = 10'd300; pac_x = 10'd300; pac_y = 10'd300; frames(1);
    check("red_eaten", a_red, 0);
    check("ghost_score", a_score, 31);
    check("ghost_lives", a_lives, 3);
    pac_x = '0; pac_y = '0; park_ghosts();
    frames(294);
    check("rev_last", a_reversal, 1);
    frames(1);
    check("rev_expired", a_reversal, 0);

    // Three lethal hits with green held overlapping
    pac_x = 10'd400; pac_y = 10'd400; green_x = 10'd402; green_y = 10'd398;
    frames(1);
    check("hit1_lives", a_lives, 2);
    check("hit1_respawn", respawn_cnt, 1);
    frames(60);
    check("hit_window", a_lives, 2);
    frames(1);
    check("hit2_lives", a_lives, 1);
    check("hit2_respawn", respawn_cnt, 2);
    frames(61);
    check("hit3_death", a_death, 1);
    check("hit3_lives", a_lives, 1);
    check("hit3_respawn", respawn_cnt, 2);
    frames(2);
    check("dead_frozen", a_score, 31);

    // Restart from DEAD
    pac_x = '0; pac_y = '0; park_ghosts(); restart = 1'b1;
    frames(1);
    restart = 1'b0;
    check("rs_score", a_score, 0);
    check("rs_lives", a_lives, 3);
    check("rs_death", a_death, 0);
    check("rs_respawn", respawn_cnt, 3);
    check("rs_dots", a_dots === dots_init, 1);
    check("rs_enables", {a_aqua, a_green, a_red, a_f2, a_f1, a_f0}, 6'b111111);

    // Last dot together with a lethal ghost: WON wins
    pac_x = 10'd56;  pac_y = 10'd56; frames(1);
    pac_x = 10'd64;  frames(1);
    pac_x = 10'd96;  pac_y = 10'd96; frames(1);
    check("three_dots", a_score, 3);
    pac_x = 10'd384; pac_y = 10'd384; aqua_x = 10'd384; aqua_y = 10'd384;
    frames(1);
    check("won_victory", a_victory, 1);
    check("won_death", a_death, 0);
    check("won_lives", a_lives, 3);
    check("won_score", a_score, 4);
    check("won_dots_empty", a_dots == '0, 1);

    // Restart from WON
    pac_x = '0; pac_y = '0; park_ghosts(); restart = 1'b1;
    frames(1);
    restart = 1'b0;
    check("rw_victory", a_victory, 0);
    check("rw_score", a_score, 0);
    check("rw_dots", a_dots === dots_init, 1);
    check("rw_respawn", respawn_cnt, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
